// File: rtl/md_unit.sv
// Iterative multiply/divide unit with HI/LO registers: MULT/MULTU/DIV/DIVU behind one start/busy handshake.
// Optional build macro MD_EARLY_OUT_EN: multiply leaves CALC once the remaining multiplier is zero.
module md_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_wea,
  input  logic             lo_wea,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned    CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t                 r_state, w_next;
  logic [CW-1:0]          r_cnt;
  logic                   r_is_div, r_neg_q, r_neg_r, r_b_zero, r_done, r_div0;
  logic [WIDTH-1:0]       r_a, r_sh, r_hi, r_lo;
  logic [2*WIDTH-1:0]     r_opd, r_acc;

  logic                   w_signed, w_neg_a, w_neg_b;
  logic [WIDTH-1:0]       w_abs_a, w_abs_b;
  logic [2*WIDTH-1:0]     w_mul_acc, w_prod;
  logic [WIDTH:0]         w_trial;
  logic                   w_trial_ok;
  logic [WIDTH-1:0]       w_quo, w_rem;

  assign w_signed = ~op[0];
  assign w_neg_a  = w_signed & a[WIDTH-1];
  assign w_neg_b  = w_signed & b[WIDTH-1];
  assign w_abs_a  = w_neg_a ? -a : a;
  assign w_abs_b  = w_neg_b ? -b : b;

  // Shared datapath: for multiply r_sh is the remaining multiplier and r_opd the shifted multiplicand;
  // for divide r_sh is dividend-in/quotient-out, r_opd[WIDTH-1:0] the divisor, r_acc[WIDTH-1:0] the remainder.
  assign w_mul_acc  = r_sh[0] ? (r_acc + r_opd) : r_acc;
  assign w_trial    = {r_acc[WIDTH-1:0], r_sh[WIDTH-1]} - {1'b0, r_opd[WIDTH-1:0]};
  assign w_trial_ok = ~w_trial[WIDTH];

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_sh : r_sh;
  assign w_rem  = r_neg_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_CALC;
      S_CALC: begin
        if (r_cnt == LAST) w_next = S_FIX;
`ifdef MD_EARLY_OUT_EN
        else if (!r_is_div && r_sh[WIDTH-1:1] == '0) w_next = S_FIX;
`endif
      end
      S_FIX:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b_zero <= 1'b0;
      r_done   <= 1'b0;
      r_div0   <= 1'b0;
      r_a      <= '0;
      r_sh     <= '0;
      r_opd    <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (hi_wea) r_hi <= wdata;
          if (lo_wea) r_lo <= wdata;
          if (start) begin
            r_cnt    <= '0;
            r_is_div <= op[1];
            r_neg_q  <= w_neg_a ^ w_neg_b;
            r_neg_r  <= w_neg_a;
            r_b_zero <= (b == '0);
            r_div0   <= 1'b0;
            r_a      <= a;
            r_sh     <= op[1] ? w_abs_a : w_abs_b;
            r_opd    <= {{WIDTH{1'b0}}, (op[1] ? w_abs_b : w_abs_a)};
            r_acc    <= '0;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_is_div) begin
            if (w_trial_ok) begin
              r_acc <= {{WIDTH{1'b0}}, w_trial[WIDTH-1:0]};
              r_sh  <= {r_sh[WIDTH-2:0], 1'b1};
            end else begin
              r_acc <= {{WIDTH{1'b0}}, r_acc[WIDTH-2:0], r_sh[WIDTH-1]};
              r_sh  <= {r_sh[WIDTH-2:0], 1'b0};
            end
          end else begin
            r_acc <= w_mul_acc;
            r_opd <= r_opd << 1;
            r_sh  <= r_sh >> 1;
          end
        end
        S_FIX: begin
          r_done <= 1'b1;
          if (!r_is_div) begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end else if (r_b_zero) begin
            r_hi   <= r_a;
            r_lo   <= '1;
            r_div0 <= 1'b1;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = r_done;
  assign div0   = r_div0;
  assign hi_out = r_hi;
  assign lo_out = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit at WIDTH=32: products, quotients, divide-by-zero, handshake and reset cases.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset, start, hi_wea, lo_wea;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done, div0;
  logic [31:0] hi_out, lo_out;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  md_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_wea(hi_wea), .lo_wea(lo_wea), .wdata(wdata),
    .busy(busy), .done(done), .div0(div0), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected start-to-result latency in cycles.
  function automatic int exp_lat(input logic [1:0] p_op, input logic [31:0] p_b);
    int lat;
    lat = 33;
`ifdef MD_EARLY_OUT_EN
    if (!p_op[1]) begin
      logic [31:0] mag;
      int msb;
      mag = (!p_op[0] && p_b[31]) ? -p_b : p_b;
      msb = -1;
      for (int i = 0; i < 32; i++) if (mag[i]) msb = i;
      lat = (msb < 0) ? 2 : msb + 2;
    end
`endif
    return lat;
  endfunction

  task automatic run_op(input string tag, input logic [1:0] p_op, input logic [31:0] p_a,
                        input logic [31:0] p_b, input logic [31:0] e_hi, input logic [31:0] e_lo,
                        input logic e_div0, input logic inject);
    int lat;
    start = 1'b1; op = p_op; a = p_a; b = p_b;
    tick();
    start = 1'b0; hi_wea = 1'b0; lo_wea = 1'b0;
    chk({tag, ".busy_at_start"}, busy, 1);
    chk({tag, ".done_at_start"}, done, 0);
    chk({tag, ".div0_at_start"}, div0, 0);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      chk({tag, ".busy_calc"}, busy, 1);
      chk({tag, ".hi_hold"}, hi_out, m_hi);
      chk({tag, ".lo_hold"}, lo_out, m_lo);
      if (inject && lat == 1) begin
        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd0;
        hi_wea = 1'b1; lo_wea = 1'b1; wdata = 32'hDEADBEEF;
      end
      tick();
      start = 1'b0; hi_wea = 1'b0; lo_wea = 1'b0;
      lat++;
    end
    chk({tag, ".latency"}, lat, exp_lat(p_op, p_b));
    chk({tag, ".busy_end"}, busy, 0);
    chk({tag, ".hi"}, hi_out, e_hi);
    chk({tag, ".lo"}, lo_out, e_lo);
    chk({tag, ".div0"}, div0, e_div0);
    m_hi = e_hi;
    m_lo = e_lo;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_wea = 1'b0; lo_wea = 1'b0; wdata = '0;
    repeat (3) tick();
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.div0", div0, 0);
    chk("reset.hi", hi_out, 0);
    chk("reset.lo", lo_out, 0);
    #3 reset = 1'b0;
    tick();

    run_op("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0);
    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
    run_op("div_m7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0);
    run_op("div_7_m2", 2'b10, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b0);
    run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);
    run_op("divu_by0", 2'b11, 32'd10, 32'd0, 32'h0000000A, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_op("multu_clr", 2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b0);
    run_op("div_by0_neg", 2'b10, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_op("mult_inject", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b1);

    lo_wea = 1'b1; wdata = 32'h12345678;
    tick();
    lo_wea = 1'b0;
    chk("mtlo.lo", lo_out, 32'h12345678);
    chk("mtlo.hi", hi_out, m_hi);
    m_lo = 32'h12345678;

    hi_wea = 1'b1; wdata = 32'hCAFEF00D;
    m_hi = 32'hCAFEF00D;
    run_op("start_mthi", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1'b0);

    start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("mid_div.busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid.busy", busy, 0);
    chk("rst_mid.done", done, 0);
    chk("rst_mid.hi", hi_out, 0);
    chk("rst_mid.lo", lo_out, 0);
    #3 reset = 1'b0;
    m_hi = '0; m_lo = '0;
    tick();
    chk("post_rst.busy", busy, 0);
    run_op("post_rst_multu", 2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b0);
    run_op("multu_3x1", 2'b01, 32'd3, 32'd1, 32'd0, 32'd3, 1'b0, 1'b0);
    run_op("mult_neg_neg", 2'b00, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd0, 32'd6, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multiply/divide unit with built-in HI/LO registers. It replaces the four separate MULT/MULTU/DIV/DIVU engines, the HI and LO registers, and the result muxes between them in the multicycle CPU. The unit runs one iterative operation at a time, selected by an opcode, behind a single start/busy handshake. It also accepts direct HI/LO writes for MTHI/MTLO, and the controller reads the results from `hi_out`/`lo_out`.

## Interface
- `WIDTH`, default 32: operand and HI/LO width; must be ≥ 4.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin operation; sampled only in IDLE.
- `op`  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  WIDTH  multiplicand or dividend (rs).
- `b`  in  WIDTH  multiplier or divisor (rt).
- `hi_wea`  in  1  direct HI write (MTHI).
- `lo_wea`  in  1  direct LO write (MTLO).
- `wdata`  in  WIDTH  direct-write data.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse when HI/LO hold a new result.
- `div0`  out  1  the last DIV/DIVU had divisor 0.
- `hi_out`  out  WIDTH  HI register.
- `lo_out`  out  WIDTH  LO register.

## Operation
- FSM states:
  - IDLE: `start` captures `op`, `a` and `b`, and moves to CALC.
  - CALC: one iteration per cycle. After the last iteration, moves to FIX.
  - FIX: applies the sign fix, writes HI/LO, pulses `done`, returns to IDLE.
- Signed ops (MULT, DIV) work on magnitudes. The operand signs are latched at start.
- Multiply is shift-add, LSB-first, producing a 2·WIDTH-bit product. HI gets the upper half, LO the lower half.
  - MULT: the product is negated if the operand signs differ.
- Divide is restoring, MSB-first. LO gets the quotient, HI the remainder.
  - The quotient truncates toward zero.
  - The remainder takes the sign of the dividend.
  - Most-negative dividend divided by −1: LO = most-negative value, HI = 0 (wraps, no trap).
- Divisor 0, signed or unsigned:
  - HI = `a`, LO = all ones.
  - `div0` is set in FIX.
  - `div0` clears when the next operation starts.
- `start` while busy is ignored, and the operands are not re-captured.
- Direct writes are accepted only in IDLE; `hi_wea`/`lo_wea` are ignored while busy.
- `start` together with a direct write in IDLE: both take effect. The write lands at that edge and the operation result overwrites it in FIX.
- MULT/MULTU never touch `div0`.

## Timing
- Reset values: `busy` = 0, `done` = 0, `div0` = 0, `hi_out` = 0, `lo_out` = 0, FSM = IDLE.
- Reset mid-operation aborts at once and discards the partial result.
- `start` sampled at edge k:
  - `busy` = 1 from edge k.
  - CALC occupies edges k+1 … k+WIDTH.
  - FIX is at edge k+WIDTH+1, where HI/LO update, `done` = 1 for one cycle, and `busy` = 0.
- Fixed latency from start edge to result edge is WIDTH+1 cycles (33 at WIDTH = 32).
- A new `start` is accepted on the edge after `done` rises. Back-to-back operation pitch is WIDTH+2 cycles.
- Direct writes take effect at the sampling edge and are visible the next cycle.
- `hi_out`/`lo_out` hold their previous values throughout CALC.

## Configuration
- `MD_EARLY_OUT_EN` defined:
  - Multiply leaves CALC after the first iteration in which the remaining multiplier magnitude is zero, with a minimum of one CALC cycle.
  - Latency = max(1, p+1)+1, where p is the bit index of the MSB of |b|.
  - Divide latency stays fixed.
- Not defined: every operation takes exactly WIDTH+1 cycles and there is no early-exit logic.

## Test plan
- MULT, `a`=0xFFFFFFFD, `b`=7, WIDTH=32 → after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB, and `done` pulses for exactly one cycle.
- MULTU, `a`=`b`=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 10/0 → HI=0x0000000A, LO=0xFFFFFFFF, `div0`=1. A following MULTU clears `div0` at its start.
- Handshake checks:
  - Pulse `start` and `hi_wea` while busy → no effect, and the original result arrives on time.
  - In IDLE, `lo_wea` with `wdata`=0x12345678 → `lo_out`=0x12345678 next cycle.
- Reset checks:
  - Assert `reset` 10 cycles into a DIV → `busy`, `done`, HI and LO all 0 immediately.
  - The next MULTU 3×5 then gives LO=15.
  - With `MD_EARLY_OUT_EN`: MULTU 3×1 gives `done` 2 cycles after start.
